hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
Pipeline sequencing controller for the 5-stage 64-bit pipeline. It owns the IF/ID, ID/EX and EX/MEM pipeline registers' write-enable, bubble and Flush controls, and the PC write/select controls. It resolves conditional branches sitting in EX/MEM and issues wrong-path flushes. It inserts multi-cycle load-use stalls.

Parameters:
LOAD_STALL_CYC, 1, stall cycles per load-use hazard; legal 1..15
CNT_W, 4, width of the stall down-counter; must hold LOAD_STALL_CYC

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
ID_EX_MemRead  in  1  instruction in ID/EX is a load
ID_EX_rd  in  5  destination register of the ID/EX instruction
IF_ID_rs1  in  5  source 1 of the decoding instruction
IF_ID_rs2  in  5  source 2 of the decoding instruction
EX_MEM_Branch  in  1  instruction in EX/MEM is a conditional branch
EX_MEM_Zero  in  1  ALU zero flag latched in EX/MEM
EX_MEM_Is_Greater  in  1  ALU greater flag latched in EX/MEM
EX_MEM_funct_in  in  4  funct bits latched in EX/MEM; [2:0] = funct3
PCSrc  out  1  select branch target into PC
PC_Write  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
ID_EX_Bubble  out  1  zero control bits entering ID/EX
IF_ID_Flush  out  1  clear IF/ID
ID_EX_Flush  out  1  clear ID/EX
EX_MEM_Flush  out  1  clear EX/MEM (level-sensitive in EX/MEM)
stall_cycles  out  32  perf counter (see Optional Feature)
flush_events  out  32  perf counter (see Optional Feature)

Behaviour:
- States: RUN, STALL, BR_FLUSH. Down-counter stall_cnt [CNT_W-1:0].
- branch_taken = EX_MEM_Branch & cond, using funct3 as follows:
  - 000 BEQ: Zero.
  - 001 BNE: !Zero.
  - 100 BLT: !Is_Greater & !Zero.
  - 101 BGE: Is_Greater | Zero.
  - Any other funct3: not taken.
- load_use = ID_EX_MemRead & (ID_EX_rd != 0) & ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2)).
- Default outputs in RUN with no event: PC_Write=1, IF_ID_Write=1; all others 0.
- RUN, branch_taken: this cycle PCSrc=1, PC_Write=1; next state BR_FLUSH. Branch has priority over load_use, and load_use is ignored.
- RUN, load_use with no branch_taken: this cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - If LOAD_STALL_CYC == 1, stay in RUN.
  - Else next state STALL with stall_cnt = LOAD_STALL_CYC-1.
- STALL: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cnt decrements each cycle.
  - At stall_cnt == 1, next state RUN.
  - branch_taken in STALL: PCSrc=1, PC_Write=1, next state BR_FLUSH, stall_cnt cleared to 0.
- BR_FLUSH, exactly 1 cycle:
  - IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PC_Write=0, IF_ID_Write=0, PCSrc=0.
  - PC already holds the target and is re-fetched next cycle.
  - Branch inputs are ignored; next state RUN.
  - Total taken-branch penalty: 4 cycles.
- All Flush outputs are decoded from the state register only, never from inputs, so the level-sensitive EX/MEM Flush cannot form a combinational loop.
- Reset asserted, any state:
  - Outputs forced to PC_Write=0, IF_ID_Write=0, PCSrc=0, ID_EX_Bubble=0, all three Flush=1.
  - At the clock edge: state=RUN, stall_cnt=0, counters=0.
  - The first cycle after reset is RUN. Reset mid-STALL or mid-BR_FLUSH abandons the sequence.

Optional Feature:
PERF_CNT_EN defined:
- stall_cycles increments (saturating at 2^32-1) every cycle ID_EX_Bubble=1.
- flush_events increments once per entry into BR_FLUSH.
- Both clear on reset.

PERF_CNT_EN undefined:
- No counter flops; both ports tied to 0. Ports exist in both builds.

Test Plan:
- Reset held 2 cycles, then released → during reset all Flush=1, PC_Write=0; first cycle after release PC_Write=1, IF_ID_Write=1, Flush=0.
- ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5, LOAD_STALL_CYC=3 → PC_Write=0, ID_EX_Bubble=1 for exactly 3 cycles, then RUN; with ID_EX_rd=0 → no stall.
- EX_MEM_Branch=1, funct3=000, Zero=1 → PCSrc=1 in cycle N; all three Flush=1 and PC_Write=0 in N+1; RUN in N+2. With funct3=001, Zero=1 → not taken, no flush.
- BLT/BGE sweep over Is_Greater/Zero ∈ {00,01,10}: BLT taken only on 00; BGE taken on 01 and 10. funct3=010 → never taken.
- load_use and branch_taken in the same cycle → branch wins: PCSrc=1, ID_EX_Bubble=0, then BR_FLUSH. Branch during STALL cycle 2 of 3 → BR_FLUSH next, stall abandoned.
- PERF_CNT_EN defined: one 3-cycle stall plus two taken branches → stall_cycles=3, flush_events=2. Undefined build → both read 0.

Source files
------------

// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline sequencing bus between the hazard/flush controller and the datapath.
// master: the controller (consumes hazard/branch info, drives stage controls).
// slave : the pipeline datapath (supplies hazard/branch info, obeys controls).
interface hazard_flush_ctrl_if;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_rd;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic        EX_MEM_Branch;
    logic        EX_MEM_Zero;
    logic        EX_MEM_Is_Greater;
    logic [3:0]  EX_MEM_funct_in;
    logic        PCSrc;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        ID_EX_Bubble;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        EX_MEM_Flush;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    modport master (
        input  ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2,
        input  EX_MEM_Branch, EX_MEM_Zero, EX_MEM_Is_Greater, EX_MEM_funct_in,
        output PCSrc, PC_Write, IF_ID_Write, ID_EX_Bubble,
        output IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        output stall_cycles, flush_events
    );

    modport slave (
        output ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2,
        output EX_MEM_Branch, EX_MEM_Zero, EX_MEM_Is_Greater, EX_MEM_funct_in,
        input  PCSrc, PC_Write, IF_ID_Write, ID_EX_Bubble,
        input  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        input  stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencing controller for the 5-stage pipeline: resolves branches in
// EX/MEM (wrong-path flush) and inserts multi-cycle load-use stalls.
// Optional macro PERF_CNT_EN: enables the stall_cycles / flush_events counters;
// when undefined both ports read 0 and no counter flops exist.
// Stall/branch controls react to inputs in the same cycle; the three Flush
// outputs are decoded from the state register (and reset) only, so the
// level-sensitive EX/MEM flush never closes a combinational loop.
module hazard_flush_ctrl #(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned CNT_W          = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_flush_ctrl_if.master  bus
);

    localparam int unsigned CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic branch_cond;
    logic branch_taken;
    logic load_use;

    logic pcsrc_c;
    logic pc_write_c;
    logic if_id_write_c;
    logic bubble_c;
    logic flush_c;

    // Branch condition decode from the funct3 latched in EX/MEM
    always_comb begin
        branch_cond = 1'b0;
        case (bus.EX_MEM_funct_in[2:0])
            3'b000:  branch_cond = bus.EX_MEM_Zero;
            3'b001:  branch_cond = ~bus.EX_MEM_Zero;
            3'b100:  branch_cond = ~bus.EX_MEM_Is_Greater & ~bus.EX_MEM_Zero;
            3'b101:  branch_cond = bus.EX_MEM_Is_Greater | bus.EX_MEM_Zero;
            default: branch_cond = 1'b0;
        endcase
        branch_taken = bus.EX_MEM_Branch & branch_cond;
    end

    assign load_use = bus.ID_EX_MemRead
                    & (bus.ID_EX_rd != 5'd0)
                    & ((bus.ID_EX_rd == bus.IF_ID_rs1) | (bus.ID_EX_rd == bus.IF_ID_rs2));

    // Next-state and control decode; branch beats load-use
    always_comb begin
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        pcsrc_c       = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        bubble_c      = 1'b0;
        flush_c       = reset | (state_q == BR_FLUSH);

        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pcsrc_c = 1'b1;
                    state_d = BR_FLUSH;
                end else if (load_use) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    bubble_c      = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        state_d     = STALL;
                        stall_cnt_d = CNT_W'(LOAD_STALL_CYC - 1);
                    end
                end
            end
            STALL: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                bubble_c      = 1'b1;
                if (branch_taken) begin
                    pcsrc_c     = 1'b1;
                    pc_write_c  = 1'b1;
                    state_d     = BR_FLUSH;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q - CNT_W'(1);
                    if (stall_cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            BR_FLUSH: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                state_d       = RUN;
            end
            default: begin
                state_d     = RUN;
                stall_cnt_d = '0;
            end
        endcase

        // Reset holds the pipeline frozen and cleared
        if (reset) begin
            pcsrc_c       = 1'b0;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            bubble_c      = 1'b0;
        end
    end

    // State and stall counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PCSrc        = pcsrc_c;
    assign bus.PC_Write     = pc_write_c;
    assign bus.IF_ID_Write  = if_id_write_c;
    assign bus.ID_EX_Bubble = bubble_c;
    assign bus.IF_ID_Flush  = flush_c;
    assign bus.ID_EX_Flush  = flush_c;
    assign bus.EX_MEM_Flush = flush_c;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    // Performance counters: bubble cycles (saturating) and BR_FLUSH entries
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (bubble_c && (stall_cycles_q != CNT_MAX)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_d == BR_FLUSH) && (state_q != BR_FLUSH)) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl (LOAD_STALL_CYC = 3): directed
// scenarios followed by random traffic, all checked against a cycle-level
// behavioural model of the sequencing rules.
module tb_hazard_flush_ctrl;

    localparam int unsigned N_STALL = 3;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    hazard_flush_ctrl_if bus();

    hazard_flush_ctrl #(.LOAD_STALL_CYC(N_STALL), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending flush cycle, remaining stall cycles, event totals
    bit      m_flush_next = 1'b0;
    int      m_stall_left = 0;
    longint  m_stalls     = 0;
    longint  m_flushes    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit taken_ref(input bit br, input bit z, input bit g, input logic [2:0] f3);
        bit c;
        case (f3)
            3'd0: c = z;
            3'd1: c = !z;
            3'd4: c = (!g) && (!z);
            3'd5: c = g || z;
            default: c = 1'b0;
        endcase
        return br && c;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic step(input bit rst, input bit mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit br, input bit z, input bit g, input logic [3:0] fn);
        bit tk, lu;
        bit e_pcsrc, e_pcw, e_ifw, e_bub, e_fl;
        reset                 = rst;
        bus.ID_EX_MemRead     = mr;
        bus.ID_EX_rd          = rd;
        bus.IF_ID_rs1         = rs1;
        bus.IF_ID_rs2         = rs2;
        bus.EX_MEM_Branch     = br;
        bus.EX_MEM_Zero       = z;
        bus.EX_MEM_Is_Greater = g;
        bus.EX_MEM_funct_in   = fn;
        #1;
        tk = taken_ref(br, z, g, fn[2:0]);
        lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

        e_pcsrc = 1'b0; e_pcw = 1'b1; e_ifw = 1'b1; e_bub = 1'b0; e_fl = 1'b0;
        if (rst) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_fl = 1'b1;
        end else if (m_flush_next) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_fl = 1'b1;
        end else if (m_stall_left > 0) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
            if (tk) begin e_pcsrc = 1'b1; e_pcw = 1'b1; end
        end else if (tk) begin
            e_pcsrc = 1'b1;
        end else if (lu) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
        end

        chk("PCSrc",        32'(bus.PCSrc),        32'(e_pcsrc));
        chk("PC_Write",     32'(bus.PC_Write),     32'(e_pcw));
        chk("IF_ID_Write",  32'(bus.IF_ID_Write),  32'(e_ifw));
        chk("ID_EX_Bubble", 32'(bus.ID_EX_Bubble), 32'(e_bub));
        chk("IF_ID_Flush",  32'(bus.IF_ID_Flush),  32'(e_fl));
        chk("ID_EX_Flush",  32'(bus.ID_EX_Flush),  32'(e_fl));
        chk("EX_MEM_Flush", 32'(bus.EX_MEM_Flush), 32'(e_fl));
        chk("stall_cycles", bus.stall_cycles, PERF ? 32'(m_stalls)  : 32'd0);
        chk("flush_events", bus.flush_events, PERF ? 32'(m_flushes) : 32'd0);

        @(posedge clk);
        if (rst) begin
            m_flush_next = 1'b0; m_stall_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (e_bub) m_stalls++;
            if (m_flush_next) begin
                m_flush_next = 1'b0;
            end else if (m_stall_left > 0) begin
                if (tk) begin
                    m_flush_next = 1'b1; m_stall_left = 0; m_flushes++;
                end else begin
                    m_stall_left--;
                end
            end else if (tk) begin
                m_flush_next = 1'b1; m_flushes++;
            end else if (lu) begin
                m_stall_left = int'(N_STALL) - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);

        // Reset held two cycles, then normal fetch
        do_reset();
        idle();
        idle();

        // Load-use on rs2: three bubble cycles, then back to RUN
        repeat (3) step(1'b0, 1'b1, 5'd5, 5'd7, 5'd5, 1'b0, 1'b0, 1'b0, 4'd0);
        idle();
        // Load into x0 never stalls
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        // Load-use on rs1
        step(1'b0, 1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(); idle(); idle();

        // BEQ taken: PCSrc, then flush cycle, then RUN
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(); idle();
        // BNE with Zero=1: not taken
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 4'd1);
        idle();

        // BLT / BGE / funct3=010 sweep over {Is_Greater, Zero}
        for (int f = 0; f < 3; f++) begin
            for (int gz = 0; gz < 3; gz++) begin
                logic [3:0] fn;
                fn = (f == 0) ? 4'd4 : ((f == 1) ? 4'd5 : 4'd2);
                step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, gz[0], gz[1], fn);
                idle(); idle();
            end
        end

        // Load-use and taken branch together: branch wins
        step(1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(); idle();

        // Branch during second stall cycle abandons the stall
        step(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 4'd1);
        idle(); idle(); idle();

        // Reset in the middle of a stall
        step(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        do_reset();
        idle();

        // Counter scenario: one 3-cycle stall plus two taken branches
        repeat (3) step(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 4'd0);
        idle();
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(); idle();
        step(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 4'd1);
        idle(); idle();
        #1;
        chk("perf_stall_total", bus.stall_cycles, PERF ? 32'd3 : 32'd0);
        chk("perf_flush_total", bus.flush_events, PERF ? 32'd2 : 32'd0);
        @(negedge clk);

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            bit rst;
            rst = ($urandom_range(0, 49) == 0);
            step(rst,
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
